sram: RTL and testbench
=======================

Name: sram

Overview:
- Single-port synchronous SRAM block: one shared address bus, write-enable, data in, registered data out.
- Serves as the node/table storage in the BDD accelerator datapath.
- Register-array implementation: every word is cleared by the asynchronous active-low reset.

Parameters:
- ADDR_WIDTH, 4, address bus width in bits.
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 16, number of implemented words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_addr  input  ADDR_WIDTH  word address for both read and write.
- i_write  input  1  write enable; 1 = write i_data to i_addr this edge.
- i_data  input  DATA_WIDTH  write data.
- o_data  output  DATA_WIDTH  registered read data.

Behaviour:
- One clock domain.
- Reset is asynchronous and active-low.
  - While i_rst_n=0: o_data=0 and all DEPTH words read back as 0.
  - Clear takes effect immediately on assertion, not at the next edge.
  - Deassertion is sampled at the next i_clk rising edge. First operation occurs on the first rising edge with i_rst_n=1.
- Write: on a rising edge with i_write=1 and i_addr < DEPTH, mem[i_addr] <= i_data.
- Read: on every rising edge (i_write=0 or 1), o_data <= mem[i_addr] when i_addr < DEPTH.
  - Read latency is 1 cycle: address presented before edge N gives its data on o_data after edge N.
  - o_data holds its value between edges.
- Out-of-range address (i_addr >= DEPTH):
  - Write is ignored; no word changes.
  - Read loads o_data with 0.
  - No wrap-around or aliasing.
- Read-during-write (same edge, same address): value loaded into o_data depends on SRAM_WRITE_FIRST_EN (see below). Stored word is always the new data.
- Back-to-back writes to the same address: last write wins.
- Reset asserted mid-operation aborts any write in progress that cycle. Memory and o_data are 0 afterwards.
- i_data is fully DATA_WIDTH wide; narrower stimulus is zero-extended by the driver, not by this block.
- No handshake; the block accepts one operation per cycle, every cycle.

Optional Feature:
- Macro: SRAM_WRITE_FIRST_EN.
- Defined (write-first): on a write edge, o_data <= i_data when i_addr < DEPTH; o_data <= 0 when out of range.
- Not defined (read-first, default): on a write edge, o_data <= previous contents of mem[i_addr], the pre-write value.
- Both modes store i_data in the memory identically.

Test Plan:
- Reset:
  - Drive i_rst_n=0 mid-cycle with no clock edge -> o_data=0 immediately.
  - Release, then read addresses 0..15 -> all return 0x00000000.
- Write/readback:
  - Write addr0=0x00020601, addr1=0x00000403, addr2=0x00000805, addr3=0x00000D01, addr4=0x00020302, addr5=0x00020407, addr6=0x00020303, addr7=0x00020303 on consecutive edges.
  - Then i_write=0 and step addresses 0..7, one per cycle -> o_data shows each value exactly one cycle after its address.
- Read-during-write:
  - Preload addr3=0x11111111, then write addr3=0x22222222.
  - o_data after that edge = 0x11111111 without SRAM_WRITE_FIRST_EN, 0x22222222 with it.
  - Next read of addr3 = 0x22222222 in both modes.
- Out of range:
  - Instantiate with DEPTH=12.
  - Write addr13=0xDEADBEEF -> ignored; read addr13 -> 0.
  - Read addr1 (wraps only if aliasing were implemented) -> unchanged previous value.
- Reset mid-operation:
  - Fill addr0..7, assert i_rst_n=0 for 3 ns between edges while i_write=1 -> o_data=0 at once.
  - After release, all addresses read 0.
- Hold/overwrite:
  - Write addr5=0xA5A5A5A5 then 0x5A5A5A5A -> read addr5 = 0x5A5A5A5A.
  - Keep i_addr constant with i_write=0 for 4 cycles -> o_data stable.

Source files
------------

// File: rtl/sram.sv
// Single-port synchronous SRAM with registered read data; every word is cleared by async reset.
// Optional macro SRAM_WRITE_FIRST_EN selects write-first read data on write edges (default read-first).
module sram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  in_range_s;
  logic                  wr_en_s;

  always_comb begin
    in_range_s = ({1'b0, i_addr} < DEPTH_L);
    wr_en_s    = i_write & in_range_s;
  end

  always_comb begin
    rdata_d = '0;
    if (in_range_s) begin
`ifdef SRAM_WRITE_FIRST_EN
      if (i_write) begin
        rdata_d = i_data;
      end else begin
        rdata_d = mem_q[i_addr];
      end
`else
      rdata_d = mem_q[i_addr];
`endif
    end else begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[i_addr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_data = rdata_q;

endmodule

// File: tb/tb_sram.sv
// Scoreboard bench for sram: two instances (DEPTH=16 and DEPTH=12) share one stimulus stream.
module tb_sram;

`ifdef SRAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        write = 1'b0;
  logic [3:0]  addr  = 4'd0;
  logic [31:0] data  = 32'd0;
  logic [31:0] o16;
  logic [31:0] o12;

  always #5 clk = ~clk;

  sram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_write(write), .i_data(data), .o_data(o16)
  );

  sram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12)) dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_write(write), .i_data(data), .o_data(o12)
  );

  typedef struct {
    logic [31:0] e16;
    logic [31:0] e12;
    logic [3:0]  a;
  } exp_t;

  exp_t        q[$];
  exp_t        push_e;
  exp_t        pop_e;
  logic [31:0] ref16 [16];
  logic [31:0] ref12 [16];
  int          checks = 0;
  int          errors = 0;

  task automatic check(string name, int a, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d got=%h expected=%h", name, a, act, exp);
    end
  endtask

  // Expected read data of a memory of the given depth for the current operation.
  function automatic logic [31:0] predict(int depth, logic [31:0] stored);
    if (int'(addr) >= depth) return 32'd0;
    if (write && WRITE_FIRST) return data;
    return stored;
  endfunction

  // Reference model: clears on reset assertion, otherwise predicts and stores per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        ref16[i] <= 32'd0;
        ref12[i] <= 32'd0;
      end
    end else begin
      push_e.a   = addr;
      push_e.e16 = predict(16, ref16[addr]);
      push_e.e12 = predict(12, ref12[addr]);
      q.push_back(push_e);
      if (write && int'(addr) < 16) ref16[addr] <= data;
      if (write && int'(addr) < 12) ref12[addr] <= data;
    end
  end

  // Monitor: compare both instances once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      pop_e = q.pop_front();
      check("rd16", int'(pop_e.a), o16, pop_e.e16);
      check("rd12", int'(pop_e.a), o12, pop_e.e12);
    end
  end

  task automatic op(logic [3:0] a, logic w, logic [31:0] d);
    @(negedge clk);
    #1;
    addr  = a;
    write = w;
    data  = d;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1;
    write = 1'b1;
    addr  = 4'd2;
    data  = 32'hCAFEF00D;
    rst_n = 1'b0;
    #1;
    check("rst_async16", 2, o16, 32'd0);
    check("rst_async12", 2, o12, 32'd0);
    #2;
    write = 1'b0;
    rst_n = 1'b1;
  endtask

  logic [31:0] fill_vals [8];

  initial begin
    fill_vals[0] = 32'h00020601; fill_vals[1] = 32'h00000403;
    fill_vals[2] = 32'h00000805; fill_vals[3] = 32'h00000D01;
    fill_vals[4] = 32'h00020302; fill_vals[5] = 32'h00020407;
    fill_vals[6] = 32'h00020303; fill_vals[7] = 32'h00020303;

    #1;
    rst_n = 1'b0;
    #1;
    check("rst_init16", 0, o16, 32'd0);
    check("rst_init12", 0, o12, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) op(4'(i), 1'b0, 32'd0);

    for (int i = 0; i < 8; i++) op(4'(i), 1'b1, fill_vals[i]);
    for (int i = 0; i < 8; i++) op(4'(i), 1'b0, 32'd0);

    op(4'd3, 1'b1, 32'h11111111);
    op(4'd3, 1'b1, 32'h22222222);
    op(4'd3, 1'b0, 32'd0);

    op(4'd11, 1'b1, 32'h0B0B0B0B);
    op(4'd12, 1'b1, 32'h0C0C0C0C);
    op(4'd15, 1'b1, 32'h0F0F0F0F);
    op(4'd13, 1'b1, 32'hDEADBEEF);
    op(4'd13, 1'b0, 32'd0);
    op(4'd1,  1'b0, 32'd0);
    op(4'd11, 1'b0, 32'd0);
    op(4'd12, 1'b0, 32'd0);
    op(4'd15, 1'b0, 32'd0);

    op(4'd5, 1'b1, 32'hA5A5A5A5);
    op(4'd5, 1'b1, 32'h5A5A5A5A);
    repeat (4) op(4'd5, 1'b0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      op(4'($urandom_range(15)), 1'($urandom_range(1)), $urandom);
    end

    for (int i = 0; i < 8; i++) op(4'(i), 1'b1, $urandom | 32'h1);
    reset_pulse();
    for (int i = 0; i < 16; i++) op(4'(i), 1'b0, 32'd0);

    @(negedge clk);
    #1;
    write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
